// File: rtl/prio_select_arbiter.sv
// N-way valid/ready arbiter: lowest index wins, with per-requester wait counters
// that promote starving requesters. The winning beat lands in a one-stage output register.
module prio_select_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_WAIT = 3,
  localparam int unsigned GW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [GW-1:0]    out_grant,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic [7:0]       cnt_q [N];
  logic [7:0]       cnt_d [N];
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [GW-1:0]    out_grant_q, out_grant_d;
  logic             out_valid_q, out_valid_d;

  logic [N-1:0]     starving;
  logic             win_found;
  logic [GW-1:0]    win_idx;
  logic             load;
  logic             xfer;

  always_comb begin
    starving = '0;
    for (int i = 0; i < N; i++) begin
      starving[i] = in_valid[i] && (MAX_WAIT != 0) && (cnt_q[i] == MaxWait);
    end
  end

  // Descending scan so the lowest matching index is the last assignment.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((|starving) ? starving[i] : in_valid[i]) begin
        win_found = 1'b1;
        win_idx   = GW'(i);
      end
    end
  end

  assign load = !out_valid_q || out_ready;
  assign xfer = load && win_found && !rst;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (win_idx == GW'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_grant_d = out_grant_q;
    if (load) begin
      out_valid_d = win_found;
      if (win_found) begin
        out_grant_d = win_idx;
        for (int i = 0; i < N; i++) begin
          if (win_idx == GW'(i)) out_data_d = in_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Counters never exceed MaxWait, so the saturating increment cannot wrap.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!in_valid[i]) begin
        cnt_d[i] = 8'd0;
      end else if (xfer) begin
        if (win_idx == GW'(i)) begin
          cnt_d[i] = 8'd0;
        end else begin
          cnt_d[i] = (cnt_q[i] >= MaxWait) ? MaxWait : cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_grant_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= 8'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_grant_q <= out_grant_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_grant = out_grant_q;

endmodule

// File: tb/tb_prio_select_arbiter.sv
// Bench for prio_select_arbiter: one fixed-priority and one aging instance share stimulus;
// directed scenarios plus randomized traffic against a behavioural model.
module tb_prio_select_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int GW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic           out_ready = 1'b1;

  logic [N-1:0]   rdy0, rdy1;
  logic [W-1:0]   od0, od1;
  logic [GW-1:0]  og0, og1;
  logic           ov0, ov1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  prio_select_arbiter #(.N(N), .WIDTH(W), .MAX_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .out_data(od0), .out_grant(og0), .out_valid(ov0), .out_ready(out_ready)
  );

  prio_select_arbiter #(.N(N), .WIDTH(W), .MAX_WAIT(3)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .out_data(od1), .out_grant(og1), .out_valid(ov1), .out_ready(out_ready)
  );

  // Behavioural model, index 0 mirrors dut0 (no aging), index 1 mirrors dut1.
  int         mw [2] = '{0, 3};
  logic       mv [2];
  logic [7:0] md [2];
  int         mg [2];
  int         mc [2][N];

  function automatic int winner(int c);
    int w = -1;
    int s = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) w = i;
      if (in_valid[i] && mw[c] != 0 && mc[c][i] == mw[c]) s = i;
    end
    return (s >= 0) ? s : w;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        mv[c] <= 1'b0;
        md[c] <= '0;
        mg[c] <= 0;
        for (int i = 0; i < N; i++) mc[c][i] <= 0;
      end else begin
        if (!mv[c] || out_ready) begin
          mv[c] <= (winner(c) >= 0);
          if (winner(c) >= 0) begin
            md[c] <= in_data[winner(c)*W +: W];
            mg[c] <= winner(c);
          end
        end
        for (int i = 0; i < N; i++) begin
          if (!in_valid[i]) mc[c][i] <= 0;
          else if ((!mv[c] || out_ready) && winner(c) >= 0)
            mc[c][i] <= (i == winner(c)) ? 0 : ((mc[c][i] + 1 > mw[c]) ? mw[c] : mc[c][i] + 1);
        end
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    next_cycle();
    rst = 1'b1;
    in_valid = '0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    in_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      total++; if (rdy1 !== 4'b0000) $display("FAIL reset_in_ready: got %b expected 0000", rdy1); else passed++;
      total++; if (ov1 !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ov1); else passed++;
      total++; if (od1 !== 8'h00) $display("FAIL reset_out_data: got %h expected 00", od1); else passed++;
      total++; if (og1 !== 2'd0) $display("FAIL reset_out_grant: got %0d expected 0", og1); else passed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed_priority();
    next_cycle();
    in_valid = 4'b0110;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      total++; if (rdy0 !== 4'b0010) $display("FAIL fixed_in_ready[%0d]: got %b expected 0010", k, rdy0); else passed++;
      next_cycle();
      total++; if (ov0 !== 1'b1) $display("FAIL fixed_valid[%0d]: got %b expected 1", k, ov0); else passed++;
      total++; if (og0 !== 2'd1) $display("FAIL fixed_grant[%0d]: got %0d expected 1", k, og0); else passed++;
      total++; if (od0 !== 8'h11) $display("FAIL fixed_data[%0d]: got %h expected 11", k, od0); else passed++;
    end
  endtask

  task automatic test_aging();
    int seq [10] = '{0, 0, 0, 1, 2, 3, 0, 1, 2, 3};
    apply_reset();
    in_valid = 4'b1111;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      total++; if (rdy1 !== 4'(1 << seq[k])) $display("FAIL aging_in_ready[%0d]: got %b expected %b", k, rdy1, 4'(1 << seq[k])); else passed++;
      next_cycle();
      total++; if (ov1 !== 1'b1) $display("FAIL aging_valid[%0d]: got %b expected 1", k, ov1); else passed++;
      total++; if (og1 !== 2'(seq[k])) $display("FAIL aging_grant[%0d]: got %0d expected %0d", k, og1, seq[k]); else passed++;
      total++; if (od1 !== 8'(8'h10 + seq[k])) $display("FAIL aging_data[%0d]: got %h expected %h", k, od1, 8'(8'h10 + seq[k])); else passed++;
    end
  endtask

  task automatic test_backpressure();
    int seq [4] = '{0, 0, 0, 1};
    apply_reset();
    in_valid = 4'b0100;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    #1;
    total++; if (rdy1 !== 4'b0100) $display("FAIL bp_load_ready: got %b expected 0100", rdy1); else passed++;
    next_cycle();
    in_valid = 4'b1111;
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      total++; if (rdy1 !== 4'b0000) $display("FAIL bp_in_ready[%0d]: got %b expected 0000", k, rdy1); else passed++;
      total++; if (ov1 !== 1'b1) $display("FAIL bp_valid[%0d]: got %b expected 1", k, ov1); else passed++;
      total++; if (od1 !== 8'h12) $display("FAIL bp_data[%0d]: got %h expected 12", k, od1); else passed++;
      total++; if (og1 !== 2'd2) $display("FAIL bp_grant[%0d]: got %0d expected 2", k, og1); else passed++;
      next_cycle();
    end
    out_ready = 1'b1;
    #1;
    total++; if (rdy1 !== 4'b0001) $display("FAIL bp_drain_ready: got %b expected 0001", rdy1); else passed++;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      total++; if (ov1 !== 1'b1) $display("FAIL bp_refill_valid[%0d]: got %b expected 1", k, ov1); else passed++;
      total++; if (og1 !== 2'(seq[k])) $display("FAIL bp_refill_grant[%0d]: got %0d expected %0d", k, og1, seq[k]); else passed++;
    end
    total++; if (od1 !== 8'h11) $display("FAIL bp_refill_data: got %h expected 11", od1); else passed++;
  endtask

  task automatic test_empty_drain();
    apply_reset();
    in_valid = 4'b1000;
    in_data = {8'hA5, 8'h00, 8'h00, 8'h00};
    out_ready = 1'b1;
    #1;
    total++; if (rdy1 !== 4'b1000) $display("FAIL drain_in_ready: got %b expected 1000", rdy1); else passed++;
    next_cycle();
    in_valid = 4'b0000;
    #1;
    total++; if (ov1 !== 1'b1) $display("FAIL drain_valid_hi: got %b expected 1", ov1); else passed++;
    total++; if (og1 !== 2'd3) $display("FAIL drain_grant: got %0d expected 3", og1); else passed++;
    total++; if (od1 !== 8'hA5) $display("FAIL drain_data: got %h expected a5", od1); else passed++;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      total++; if (ov1 !== 1'b0) $display("FAIL drain_valid_lo[%0d]: got %b expected 0", k, ov1); else passed++;
      total++; if (od1 !== 8'hA5) $display("FAIL drain_data_hold[%0d]: got %h expected a5", k, od1); else passed++;
      total++; if (og1 !== 2'd3) $display("FAIL drain_grant_hold[%0d]: got %0d expected 3", k, og1); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int seq [4] = '{0, 0, 0, 1};
    apply_reset();
    in_valid = 4'b1111;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) next_cycle();
    rst = 1'b1;
    #1;
    total++; if (rdy1 !== 4'b0000) $display("FAIL mid_rst_ready: got %b expected 0000", rdy1); else passed++;
    next_cycle();
    total++; if (ov1 !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", ov1); else passed++;
    total++; if (od1 !== 8'h00) $display("FAIL mid_rst_data: got %h expected 00", od1); else passed++;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (rdy1 !== 4'(1 << seq[k])) $display("FAIL mid_restart_ready[%0d]: got %b expected %b", k, rdy1, 4'(1 << seq[k])); else passed++;
      next_cycle();
      total++; if (og1 !== 2'(seq[k])) $display("FAIL mid_restart_grant[%0d]: got %0d expected %0d", k, og1, seq[k]); else passed++;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_rdy;
    for (int k = 0; k < 400; k++) begin
      next_cycle();
      rst = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'($urandom);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int c = 0; c < 2; c++) begin
        exp_rdy = '0;
        if (!rst && (!mv[c] || out_ready) && winner(c) >= 0) exp_rdy[winner(c)] = 1'b1;
        total++; if (((c == 0) ? rdy0 : rdy1) !== exp_rdy)
          $display("FAIL rand_in_ready[%0d/%0d]: got %b expected %b", c, k, (c == 0) ? rdy0 : rdy1, exp_rdy); else passed++;
        total++; if (((c == 0) ? ov0 : ov1) !== mv[c])
          $display("FAIL rand_valid[%0d/%0d]: got %b expected %b", c, k, (c == 0) ? ov0 : ov1, mv[c]); else passed++;
        total++; if (((c == 0) ? od0 : od1) !== md[c])
          $display("FAIL rand_data[%0d/%0d]: got %h expected %h", c, k, (c == 0) ? od0 : od1, md[c]); else passed++;
        total++; if (((c == 0) ? og0 : og1) !== 2'(mg[c]))
          $display("FAIL rand_grant[%0d/%0d]: got %0d expected %0d", c, k, (c == 0) ? og0 : og1, mg[c]); else passed++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_aging();
    test_backpressure();
    test_empty_drain();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prio_select_arbiter.md
Name: prio_select_arbiter

Overview:
- Arbitrates N valid/ready requesters onto one registered output channel using first-match priority: the lowest index wins.
- Per-requester wait counters prevent starvation by promoting long-waiting requesters.
- Sits in front of a shared sink. It sequences the priority select-one-first datapath and adds handshakes plus a one-stage output register.

Parameters:
- N, 4, number of requesters (2..16).
- WIDTH, 8, data width per requester.
- MAX_WAIT, 3, losses before a requester becomes starving. 0 disables aging (pure fixed priority). Range 0..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*WIDTH  packed requester data; requester i at bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-requester valid.
- in_ready  output  N  per-requester ready; at most one bit set.
- out_data  output  WIDTH  registered winning data.
- out_grant  output  clog2(N)  registered index of the requester that supplied out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  sink accepts out_data this cycle.

Behaviour:
- Reset: out_valid=0, out_data=0, out_grant=0, all wait counters=0.
- in_ready is 0 during rst.

Load enable:
- load = !out_valid | out_ready.
- This is a pipelined single stage: a full register can be drained and refilled in the same cycle.

Winner selection (combinational, from current state):
- starving[i] = in_valid[i] & (MAX_WAIT!=0) & (cnt[i]==MAX_WAIT).
- If any starving bit is set, the winner is the lowest-index starving requester.
- Otherwise the winner is the lowest-index valid requester.
- No valid requester means no winner.

in_ready:
- in_ready[w] = load & winner exists.
- All other in_ready bits are 0.
- in_ready never depends on in_valid of other requesters except through winner selection.

Transfer:
- When in_valid[w] & in_ready[w], on the next edge: out_data <= in_data[w], out_grant <= w, out_valid <= 1.
- Latency from input handshake to out_valid is 1 cycle.
- If load=1 and no winner: out_valid <= 0; out_data and out_grant hold their values.
- If load=0 (out_valid & !out_ready): out_data, out_grant and out_valid hold. Input data must not be sampled.

Wait counters (cnt[i], 8-bit):
- Updated only on cycles where a transfer occurs, so output stalls do not age requesters.
- On a transfer cycle:
  - winner: cnt <= 0;
  - other requesters with in_valid=1: cnt <= min(cnt+1, MAX_WAIT);
  - requesters with in_valid=0: cnt <= 0.
- On non-transfer cycles, a requester that drops in_valid clears its counter. All other counters hold.

Boundary conditions:
- MAX_WAIT=0: counters stay 0; behaviour is pure fixed priority.
- N=2: out_grant is 1 bit.
- Simultaneous drain and refill: out_ready=1 with a winner present keeps out_valid=1 with new data, so there is no bubble.
- Reset mid-transfer: the output register empties (out_valid=0) and the pending beat is dropped. The requester holds valid and is re-arbitrated from zeroed counters.
- Requesters may deassert in_valid without a handshake. The arbiter must not require valid to be sticky.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_grant=0 throughout reset.
- Fixed priority, MAX_WAIT=0: in_valid=4'b0110, data i = 8'h10+i, out_ready=1 -> out_grant=1, out_data=8'h11 every cycle; in_ready=4'b0010; requester 2 never served.
- Aging, MAX_WAIT=3: all four valid continuously, out_ready=1 -> out_grant sequence 0,0,0,1,2,3,0,1,2,3,... (one grant per cycle after first-cycle latency).
- Backpressure: request 2 loaded (8'h12), then out_ready=0 for 5 cycles while in_valid=4'b1111 -> out_data holds 8'h12, in_ready=0, counters unchanged. out_ready=1 then drains and loads requester 0 on the same edge with no out_valid bubble.
- Empty drain: single request from requester 3 (8'hA5) accepted, then in_valid=0, out_ready=1 -> out_valid=1 for exactly 1 cycle with out_grant=3, then 0; out_data stays 8'hA5.
- Reset mid-operation: rst asserted while out_valid=1 and counters nonzero -> next cycle out_valid=0. After release with all valid, the grant sequence restarts at 0,0,0,1.
